// File: rtl/sprite_line_fetcher.sv
// Sprite line fetcher.
// Fetches one row of a SPR_W x SPR_H sprite (8-bit palette index per pixel, two pixels per
// 16-bit ROM word) into a line buffer during horizontal blanking, then serves pixels to the
// compositor during active video with one cycle of latency.
//
// Ports:
//   clk_i           system clock
//   reset_ni        synchronous active-low reset
//   line_start_i    one-cycle pulse at start of hblank; samples next_line/sprite_x/y/en
//   next_line_i     scanline displayed after this blanking
//   sprite_x_i      sprite left column
//   sprite_y_i      sprite top line
//   sprite_en_i     sprite enable
//   hactive_i       active-video qualifier
//   hcount_i        current active column
//   rom_address_o   ROM word address (0 when not fetching)
//   rom_clken_o     ROM clock enable, high only while addresses are issued
//   rom_readdata_i  ROM data, valid one cycle after the address
//   pix_index_o     palette index for the current pixel
//   pix_valid_o     opaque sprite pixel present
//   fetch_busy_o    high while a row fetch is in progress
//   fetch_abort_o   one-cycle pulse when a running fetch is restarted
module sprite_line_fetcher #(
   parameter int unsigned SPR_W       = 16,
   parameter int unsigned SPR_H       = 16,
   parameter int unsigned ADDR_W      = 7,
   parameter logic [7:0]  TRANSPARENT = 8'h00
) (
   input  logic              clk_i,
   input  logic              reset_ni,
   input  logic              line_start_i,
   input  logic [9:0]        next_line_i,
   input  logic [10:0]       sprite_x_i,
   input  logic [9:0]        sprite_y_i,
   input  logic              sprite_en_i,
   input  logic              hactive_i,
   input  logic [10:0]       hcount_i,
   output logic [ADDR_W-1:0] rom_address_o,
   output logic              rom_clken_o,
   input  logic [15:0]       rom_readdata_i,
   output logic [7:0]        pix_index_o,
   output logic              pix_valid_o,
   output logic              fetch_busy_o,
   output logic              fetch_abort_o
);

   localparam int unsigned Words    = SPR_W / 2;
   localparam int unsigned WW       = (Words > 1) ? $clog2(Words) : 1;
   localparam int unsigned BW       = WW + 1;
   localparam logic [WW-1:0] LastWord = WW'(Words - 1);
   localparam logic [9:0]  SprH     = 10'(SPR_H);
   localparam logic [10:0] SprW     = 11'(SPR_W);

   typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

   state_e          state_q, state_d;
   logic [WW-1:0]   w_q, w_d;
   logic            row_valid_q, row_valid_d;
   logic [9:0]      row_q;
   logic [10:0]     spr_x_q;
   logic            cap_valid_q;
   logic [WW-1:0]   cap_w_q;
   logic            abort_q;
   logic [7:0]      pix_index_q;
   logic            pix_valid_q;
   logic [7:0]      line_buf_q [SPR_W];

   // Row of the sprite for the scanline being announced; negative wraps out of range.
   logic [9:0] row_new;
   logic       row_in_range;
   assign row_new      = next_line_i - sprite_y_i;
   assign row_in_range = sprite_en_i && (row_new < SprH);

   // State register
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         state_q     <= StIdle;
         w_q         <= '0;
         row_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         w_q         <= w_d;
         row_valid_q <= row_valid_d;
      end
   end

   // Next-state logic; line_start restarts from any state.
   always_comb begin
      state_d     = state_q;
      w_d         = w_q;
      row_valid_d = row_valid_q;
      if (line_start_i) begin
         row_valid_d = 1'b0;
         w_d         = '0;
         state_d     = row_in_range ? StFetch : StIdle;
      end else begin
         case (state_q)
            StIdle: ;
            StFetch: begin
               if (w_q == LastWord) begin
                  state_d = StDrain;
               end else begin
                  w_d = w_q + WW'(1);
               end
            end
            StDrain: begin
               state_d     = StIdle;
               row_valid_d = 1'b1;
            end
            default: state_d = StIdle;
         endcase
      end
   end

   // FSM outputs
   always_comb begin
      rom_clken_o   = 1'b0;
      rom_address_o = '0;
      fetch_busy_o  = (state_q != StIdle);
      if (state_q == StFetch) begin
         rom_clken_o   = 1'b1;
         rom_address_o = ADDR_W'(row_q * Words + w_q);
      end
   end

   assign fetch_abort_o = abort_q;

   // Shadow registers, capture pointer and abort pulse
   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         row_q       <= '0;
         spr_x_q     <= '0;
         cap_valid_q <= 1'b0;
         cap_w_q     <= '0;
         abort_q     <= 1'b0;
      end else begin
         if (line_start_i) begin
            row_q   <= row_new;
            spr_x_q <= sprite_x_i;
         end
         // Data for the word issued this cycle arrives next cycle; drop it on restart.
         cap_valid_q <= (state_q == StFetch) && !line_start_i;
         cap_w_q     <= w_q;
         abort_q     <= line_start_i && (state_q != StIdle);
      end
   end

   // Line buffer: contents are masked by row_valid, so no reset needed.
   always_ff @(posedge clk_i) begin
      if (cap_valid_q) begin
         line_buf_q[{cap_w_q, 1'b0}] <= rom_readdata_i[7:0];
         line_buf_q[{cap_w_q, 1'b1}] <= rom_readdata_i[15:8];
      end
   end

   // Pixel path
   logic [10:0] col;
   logic        hit;
   logic [7:0]  buf_pix;
   assign col     = hcount_i - spr_x_q;
   assign hit     = hactive_i && row_valid_q && (col < SprW);
   assign buf_pix = line_buf_q[col[BW-1:0]];

   always_ff @(posedge clk_i) begin
      if (!reset_ni) begin
         pix_index_q <= '0;
         pix_valid_q <= 1'b0;
      end else begin
         pix_index_q <= hit ? buf_pix : 8'h00;
         pix_valid_q <= hit && (buf_pix != TRANSPARENT);
      end
   end

   assign pix_index_o = pix_index_q;
   assign pix_valid_o = pix_valid_q;

endmodule

// File: tb/tb_sprite_line_fetcher.sv
// Directed bench for sprite_line_fetcher with a ROM model and scoreboard queues for ROM
// addresses and pixel outputs.
module tb_sprite_line_fetcher;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        line_start;
   logic [9:0]  next_line;
   logic [10:0] sprite_x;
   logic [9:0]  sprite_y;
   logic        sprite_en;
   logic        hactive;
   logic [10:0] hcount;
   logic [6:0]  rom_address;
   logic        rom_clken;
   logic [15:0] rom_readdata;
   logic [7:0]  pix_index;
   logic        pix_valid;
   logic        fetch_busy;
   logic        fetch_abort;

   always #5 clk = ~clk;

   sprite_line_fetcher dut (
      .clk_i          (clk),
      .reset_ni       (reset_n),
      .line_start_i   (line_start),
      .next_line_i    (next_line),
      .sprite_x_i     (sprite_x),
      .sprite_y_i     (sprite_y),
      .sprite_en_i    (sprite_en),
      .hactive_i      (hactive),
      .hcount_i       (hcount),
      .rom_address_o  (rom_address),
      .rom_clken_o    (rom_clken),
      .rom_readdata_i (rom_readdata),
      .pix_index_o    (pix_index),
      .pix_valid_o    (pix_valid),
      .fetch_busy_o   (fetch_busy),
      .fetch_abort_o  (fetch_abort)
   );

   // ROM model, one cycle latency
   logic [15:0] rom [128];
   always @(posedge clk) begin
      if (rom_clken) rom_readdata <= rom[rom_address];
   end

   int n_vec = 0;
   int n_bad = 0;

   logic [8:0] pix_sb [$];
   logic [6:0] addr_sb [$];

   // Reference view of what the line buffer should hold
   bit          m_rv;
   logic [9:0]  m_row;
   logic [10:0] m_sx;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [8:0] model_pix(input logic hact, input logic [10:0] hc);
      logic [10:0] c;
      logic [15:0] w;
      logic [7:0]  b;
      c = hc - m_sx;
      if (hact && m_rv && c < 11'd16) begin
         w = rom[{m_row[3:0], c[3:1]}];
         b = c[0] ? w[15:8] : w[7:0];
         return {b, b != 8'h00};
      end
      return 9'h000;
   endfunction

   // Pulse line_start; returns whether the model expects a fetch.
   task automatic start(input logic [9:0] nl, input logic [9:0] sy, input logic [10:0] sx,
                        input logic en, output bit inr);
      logic [9:0] r;
      r   = nl - sy;
      inr = en && (r < 10'd16);
      line_start = 1'b1;
      next_line  = nl;
      sprite_y   = sy;
      sprite_x   = sx;
      sprite_en  = en;
      hactive    = 1'b0;
      m_rv  = 0;
      m_row = r;
      m_sx  = sx;
      if (inr) begin
         for (int i = 0; i < 8; i++) addr_sb.push_back(7'({r[3:0], 3'(i)}));
      end
      step();
      line_start = 1'b0;
   endtask

   task automatic run_fetch(input bit inr, input bit exp_abort);
      logic [6:0] a;
      if (inr) begin
         for (int i = 0; i < 8; i++) begin
            chk("rom_clken", rom_clken, 1);
            a = addr_sb.pop_front();
            chk("rom_address", rom_address, a);
            chk("fetch_busy", fetch_busy, 1);
            chk("fetch_abort", fetch_abort, (exp_abort && i == 0) ? 1 : 0);
            hactive = 1'b1;
            hcount  = m_sx + 11'd1;
            step();
            chk("pix_valid_busy", pix_valid, 0);
         end
         chk("fetch_busy_drain", fetch_busy, 1);
         chk("rom_clken_drain", rom_clken, 0);
         step();
         chk("pix_valid_drain", pix_valid, 0);
         chk("fetch_busy_done", fetch_busy, 0);
         hactive = 1'b0;
         m_rv = 1;
      end else begin
         for (int i = 0; i < 10; i++) begin
            chk("rom_clken_oor", rom_clken, 0);
            chk("fetch_busy_oor", fetch_busy, 0);
            chk("fetch_abort_oor", fetch_abort, (exp_abort && i == 0) ? 1 : 0);
            step();
         end
      end
   endtask

   task automatic scan();
      logic [10:0] hc;
      logic [8:0]  e;
      for (int i = 0; i < 20; i++) begin
         hc      = m_sx + 11'(i) - 11'd2;
         hactive = 1'b1;
         hcount  = hc;
         pix_sb.push_back(model_pix(1'b1, hc));
         step();
         e = pix_sb.pop_front();
         chk("pix_index", pix_index, e[8:1]);
         chk("pix_valid", pix_valid, e[0]);
      end
      hactive = 1'b0;
   endtask

   initial begin
      bit inr;
      logic [8:0] e;
      for (int k = 0; k < 128; k++) rom[k] = {8'(k + 8'h80), 8'(k)};
      rom_readdata = '0;
      m_rv = 0; m_row = '0; m_sx = '0;

      // Reset held with line_start asserted
      reset_n = 1'b0; line_start = 1'b1; next_line = 10'd103; sprite_y = 10'd100;
      sprite_x = 11'd200; sprite_en = 1'b1; hactive = 1'b1; hcount = 11'd200;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("rst_clken", rom_clken, 0);
         chk("rst_address", rom_address, 0);
         chk("rst_busy", fetch_busy, 0);
         chk("rst_abort", fetch_abort, 0);
         chk("rst_pix_index", pix_index, 0);
         chk("rst_pix_valid", pix_valid, 0);
      end
      reset_n = 1'b1; line_start = 1'b0; hcount = 11'd0;
      pix_sb.push_back(model_pix(1'b1, 11'd0));
      step();
      e = pix_sb.pop_front();
      chk("post_rst_clken", rom_clken, 0);
      chk("post_rst_busy", fetch_busy, 0);
      chk("post_rst_pix_valid", pix_valid, e[0]);
      chk("post_rst_pix_index", pix_index, e[8:1]);
      hactive = 1'b0;

      // Basic fetch of row 3
      start(10'd103, 10'd100, 11'd200, 1'b1, inr);
      run_fetch(inr, 0);
      scan();

      // Transparent even pixel in word 24
      rom[24] = 16'h0500;
      start(10'd103, 10'd100, 11'd200, 1'b1, inr);
      run_fetch(inr, 0);
      scan();
      rom[24] = {8'h98, 8'h18};

      // Out-of-range rows and disabled sprite
      start(10'd99, 10'd100, 11'd200, 1'b1, inr);
      run_fetch(inr, 0);
      scan();
      start(10'd116, 10'd100, 11'd200, 1'b1, inr);
      run_fetch(inr, 0);
      scan();
      start(10'd103, 10'd100, 11'd200, 1'b0, inr);
      run_fetch(inr, 0);
      scan();

      // Restart four cycles into a fetch
      start(10'd103, 10'd100, 11'd200, 1'b1, inr);
      for (int i = 0; i < 4; i++) begin
         chk("abort_pre_address", rom_address, addr_sb.pop_front());
         chk("abort_pre_pulse", fetch_abort, 0);
         step();
      end
      addr_sb.delete();
      start(10'd101, 10'd100, 11'd200, 1'b1, inr);
      run_fetch(inr, 1);
      scan();

      // Sprite at column 0, then hactive low inside the sprite
      start(10'd103, 10'd100, 11'd0, 1'b1, inr);
      run_fetch(inr, 0);
      scan();
      hactive = 1'b0; hcount = 11'd5;
      pix_sb.push_back(model_pix(1'b0, 11'd5));
      step();
      e = pix_sb.pop_front();
      chk("hactive_low_valid", pix_valid, e[0]);
      chk("hactive_low_index", pix_index, e[8:1]);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/sprite_line_fetcher.md
Name: sprite_line_fetcher

Overview:
- Downstream consumer of a 128x16 single-port sprite ROM: 16x16 sprite, 8-bit palette index per pixel, 2 pixels per word, 8 words per row.
- On each line-start pulse it fetches the sprite row for the upcoming scanline into a 16-entry line buffer during horizontal blanking.
- During active video it emits the per-pixel palette index and a valid flag to the VGA compositor.
- ROM read latency is 1 cycle: the address is sampled at an edge and data is valid on `rom_readdata` in the following cycle.

Parameters:
- SPR_W, 16, sprite width in pixels (even); words per row = SPR_W/2
- SPR_H, 16, sprite height in lines
- ADDR_W, 7, ROM word-address width; must be at least log2(SPR_W/2*SPR_H)
- TRANSPARENT, 8'h00, palette index treated as transparent (pix_valid forced 0)

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous reset, active-low
- line_start  in  1  one-cycle pulse at start of horizontal blanking
- next_line  in  10  scanline to be displayed after this blanking; sampled on line_start
- sprite_x  in  11  sprite left column; sampled on line_start
- sprite_y  in  10  sprite top line; sampled on line_start
- sprite_en  in  1  sprite enable; sampled on line_start
- hactive  in  1  active-video qualifier
- hcount  in  11  current active column
- rom_address  out  ADDR_W  ROM word address
- rom_clken  out  1  ROM clock enable; high only while fetching
- rom_readdata  in  16  ROM data; valid 1 cycle after address
- pix_index  out  8  palette index for current pixel
- pix_valid  out  1  opaque sprite pixel present
- fetch_busy  out  1  high in FETCH/DRAIN
- fetch_abort  out  1  one-cycle pulse when a fetch is restarted

Behaviour:
- Reset (reset_n=0 at an edge): FSM=IDLE. rom_address=0, rom_clken=0, pix_index=0, pix_valid=0, fetch_busy=0, fetch_abort=0, row_valid=0. Line-buffer contents are don't-care, but row_valid=0 masks them.
- On line_start, latch next_line, sprite_x, sprite_y, sprite_en into shadow registers. Compute `row = next_line - sprite_y` modulo 2^10.
- Row in range iff sprite_en=1 and row < SPR_H. Negative differences wrap to large values and are out of range.
- FSM states:
  - IDLE: on line_start with row in range, clear row_valid → FETCH, word counter w=0. If row is out of range: row_valid←0, remain IDLE, no ROM access.
  - FETCH: drive `rom_address = row*(SPR_W/2) + w` with rom_clken=1, incrementing w each cycle. After the last word (w = SPR_W/2-1) is issued → DRAIN.
  - DRAIN: one cycle for the final ROM data, then row_valid←1 → IDLE.
- Data capture: rom_readdata captured into buffer entries 2*(w-1) and 2*(w-1)+1 in the cycle after address w-1. Low byte = even pixel, high byte = odd pixel.
- Total fetch: SPR_W/2+1 cycles (9 at defaults) from the cycle after line_start. fetch_busy=1 throughout.
- line_start during FETCH/DRAIN: abort the current fetch, pulse fetch_abort for 1 cycle, and restart per IDLE rules with the new sampled values. row_valid stays 0 until the new fetch completes.
- Display buffer is the fetch buffer itself. Software/timing must keep hblank ≥ SPR_W/2+2 cycles. While fetch_busy=1, pixel output is forced transparent because row_valid=0.
- Pixel path: registered, 1-cycle latency from hactive/hcount. `col = hcount - sprite_x` (11-bit, modulo).
  - If hactive=1, row_valid=1 and col < SPR_W: pix_index = buffer[col] next cycle, and pix_valid = (buffer[col] != TRANSPARENT).
  - Otherwise pix_index=0 and pix_valid=0.
- Sprite partially off the right edge: columns beyond the display are simply never requested; no special handling.
- sprite_x/sprite_y changes between line_start pulses have no effect until the next line_start.

Test Plan:
- Reset: hold reset_n=0 for 3 cycles with line_start=1 → no ROM access, all outputs 0, row_valid=0 after release.
- Basic fetch: ROM word k = {k+8'h80, k}. sprite_y=100, next_line=103, line_start → rom_address 24..31 on 8 consecutive cycles; fetch_busy high for 9 cycles. With sprite_x=200, hcount 200..215 → pix_index 24,0x98,25,0x99,…; word 24 low byte = 24.
- Transparency: ROM word 24 = 16'h0500, hcount=200 → pix_valid=0 next cycle; hcount=201 → pix_index=5, pix_valid=1.
- Out of range: next_line=99 (row wraps to 1023) or next_line=116, or sprite_en=0 → no rom_clken, pix_valid=0 across the whole line.
- Abort: second line_start 4 cycles into a fetch with next_line=101 → fetch_abort pulses once, addresses restart at 8..15, final buffer holds row 1.
- Edges: sprite_x=0, hcount=0 and 15 → valid; hcount=16 → pix_valid=0. hactive=0 with hcount in range → pix_valid=0.
